// File: rtl/snake_body_engine_pkg.sv
// Shared constants, encodings and start-state helpers for the snake body engine.
package snake_body_engine_pkg;

  localparam int CELL      = 10;
  localparam int GRID_W    = 64;
  localparam int GRID_H    = 48;
  localparam int MAX_LEN   = 33;
  localparam int BORDER_X  = 10;
  localparam int BORDER_Y  = 10;
  localparam int START_X   = 320;
  localparam int START_Y   = 240;
  localparam int START_LEN = 3;
  localparam int MAX_X     = (GRID_W - 2) * CELL;
  localparam int MAX_Y     = (GRID_H - 2) * CELL;
  localparam int X_BITS    = 10;
  localparam int Y_BITS    = 9;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK,
    ST_DEAD
  } state_t;

  // Opposite headings share the axis bit and differ only in the sign bit.
  function automatic logic is_reverse(dir_t a, dir_t b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

  function automatic logic [MAX_LEN*X_BITS-1:0] start_bus_x();
    logic [MAX_LEN*X_BITS-1:0] b;
    b = '0;
    for (int k = 0; k < MAX_LEN; k++)
      b[(MAX_LEN-k)*X_BITS-1 -: X_BITS] = X_BITS'(START_X - k*CELL);
    return b;
  endfunction

  function automatic logic [MAX_LEN*Y_BITS-1:0] start_bus_y();
    logic [MAX_LEN*Y_BITS-1:0] b;
    b = '0;
    for (int k = 0; k < MAX_LEN; k++)
      b[(MAX_LEN-k)*Y_BITS-1 -: Y_BITS] = Y_BITS'(START_Y);
    return b;
  endfunction

endpackage

// File: rtl/snake_body_engine_if.sv
// Control inputs and latched render-side outputs of the snake body engine.
interface snake_body_engine_if;
  import snake_body_engine_pkg::*;

  logic                      restart;
  logic                      step;
  logic [1:0]                dir;
  logic                      grow;
  logic                      frame_start;
  logic [X_BITS-1:0]         head_x_d;
  logic [Y_BITS-1:0]         head_y_d;
  logic [7:0]                snake_len_d;
  logic [MAX_LEN*X_BITS-1:0] body_bus_x_d;
  logic [MAX_LEN*Y_BITS-1:0] body_bus_y_d;
  logic                      busy;
  logic                      game_over;

  modport master (
    output restart, step, dir, grow, frame_start,
    input  head_x_d, head_y_d, snake_len_d, body_bus_x_d, body_bus_y_d, busy, game_over
  );

  modport slave (
    input  restart, step, dir, grow, frame_start,
    output head_x_d, head_y_d, snake_len_d, body_bus_x_d, body_bus_y_d, busy, game_over
  );

endinterface

// File: rtl/snake_body_engine_next_head.sv
// Next head cell for a heading, with a wall flag computed in signed math so underflow is caught.
module snake_next_head
  import snake_body_engine_pkg::*;
(
  input  logic [X_BITS-1:0] head_x,
  input  logic [Y_BITS-1:0] head_y,
  input  dir_t              heading,
  output logic [X_BITS-1:0] next_x,
  output logic [Y_BITS-1:0] next_y,
  output logic              wall
);

  localparam logic signed [10:0] STEP = 11'(CELL);
  localparam logic signed [10:0] LO_X = 11'(BORDER_X);
  localparam logic signed [10:0] LO_Y = 11'(BORDER_Y);
  localparam logic signed [10:0] HI_X = 11'(MAX_X);
  localparam logic signed [10:0] HI_Y = 11'(MAX_Y);

  logic signed [10:0] sx;
  logic signed [10:0] sy;

  always_comb begin
    sx = $signed({1'b0, head_x});
    sy = $signed({2'b00, head_y});
    case (heading)
      DIR_UP:    sy = sy - STEP;
      DIR_DOWN:  sy = sy + STEP;
      DIR_LEFT:  sx = sx - STEP;
      default:   sx = sx + STEP;
    endcase
    wall   = (sx < LO_X) || (sx > HI_X) || (sy < LO_Y) || (sy > HI_Y);
    next_x = sx[X_BITS-1:0];
    next_y = sy[Y_BITS-1:0];
  end

endmodule

// File: rtl/snake_body_engine.sv
// Live snake state: head move, body shift chain, growth, wall/self collision and frame snapshots.
module snake_body_engine
  import snake_body_engine_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  snake_body_engine_if.slave bus
);

  localparam int XW = MAX_LEN * X_BITS;
  localparam int YW = MAX_LEN * Y_BITS;
  localparam logic [7:0] LEN_MAX   = 8'(MAX_LEN);
  localparam logic [7:0] LEN_START = 8'(START_LEN);

  state_t            state;
  dir_t              heading;
  dir_t              step_dir;
  dir_t              move_dir;
  logic [XW-1:0]     seg_x;
  logic [YW-1:0]     seg_y;
  logic [7:0]        len;
  logic [7:0]        chk_k;
  logic              grow_pend;
  logic              snap_pend;
  logic              snap_req;
  logic              step_ok;
  logic              grow_now;
  logic              wall;
  logic              hit;
  logic [X_BITS-1:0] next_x;
  logic [Y_BITS-1:0] next_y;
  logic [X_BITS-1:0] cmp_x;
  logic [Y_BITS-1:0] cmp_y;

  assign step_dir = is_reverse(dir_t'(bus.dir), heading) ? heading : dir_t'(bus.dir);
  // heading is already updated by the time SHIFT runs, so the same adder serves both states
  assign move_dir = (state == ST_IDLE) ? step_dir : heading;
  assign step_ok  = (state == ST_IDLE) && bus.step;
  assign snap_req = bus.frame_start || snap_pend;
  assign grow_now = grow_pend && (len < LEN_MAX);

  snake_next_head u_next_head (
    .head_x  (seg_x[XW-1 -: X_BITS]),
    .head_y  (seg_y[YW-1 -: Y_BITS]),
    .heading (move_dir),
    .next_x  (next_x),
    .next_y  (next_y),
    .wall    (wall)
  );

  always_comb begin
    cmp_x = '0;
    cmp_y = '0;
    for (int k = 1; k < MAX_LEN; k++) begin
      if (chk_k == 8'(k)) begin
        cmp_x = seg_x[(MAX_LEN-k)*X_BITS-1 -: X_BITS];
        cmp_y = seg_y[(MAX_LEN-k)*Y_BITS-1 -: Y_BITS];
      end
    end
  end

  assign hit = (cmp_x == seg_x[XW-1 -: X_BITS]) && (cmp_y == seg_y[YW-1 -: Y_BITS]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      heading           <= DIR_RIGHT;
      seg_x             <= start_bus_x();
      seg_y             <= start_bus_y();
      len               <= LEN_START;
      chk_k             <= 8'd1;
      grow_pend         <= 1'b0;
      snap_pend         <= 1'b0;
      bus.busy          <= 1'b0;
      bus.game_over     <= 1'b0;
      bus.head_x_d      <= X_BITS'(START_X);
      bus.head_y_d      <= Y_BITS'(START_Y);
      bus.snake_len_d   <= LEN_START;
      bus.body_bus_x_d  <= start_bus_x();
      bus.body_bus_y_d  <= start_bus_y();
    end else if (bus.restart) begin
      state             <= ST_IDLE;
      heading           <= DIR_RIGHT;
      seg_x             <= start_bus_x();
      seg_y             <= start_bus_y();
      len               <= LEN_START;
      chk_k             <= 8'd1;
      grow_pend         <= 1'b0;
      snap_pend         <= 1'b0;
      bus.busy          <= 1'b0;
      bus.game_over     <= 1'b0;
      bus.head_x_d      <= X_BITS'(START_X);
      bus.head_y_d      <= Y_BITS'(START_Y);
      bus.snake_len_d   <= LEN_START;
      bus.body_bus_x_d  <= start_bus_x();
      bus.body_bus_y_d  <= start_bus_y();
    end else begin
      // Defer across an accepted step and its SHIFT so the renderer sees the post-shift state.
      if (state == ST_SHIFT || step_ok) begin
        snap_pend <= snap_req;
      end else if (snap_req) begin
        snap_pend        <= 1'b0;
        bus.head_x_d     <= seg_x[XW-1 -: X_BITS];
        bus.head_y_d     <= seg_y[YW-1 -: Y_BITS];
        bus.snake_len_d  <= len;
        bus.body_bus_x_d <= seg_x;
        bus.body_bus_y_d <= seg_y;
      end

      case (state)
        ST_IDLE: begin
          if (bus.grow) grow_pend <= 1'b1;
          if (bus.step) begin
            heading <= step_dir;
            if (wall) begin
              state         <= ST_DEAD;
              bus.game_over <= 1'b1;
            end else begin
              state    <= ST_SHIFT;
              bus.busy <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          seg_x     <= {next_x, seg_x[XW-1:X_BITS]};
          seg_y     <= {next_y, seg_y[YW-1:Y_BITS]};
          grow_pend <= bus.grow;
          chk_k     <= 8'd1;
          if (grow_now) len <= len + 8'd1;
          if (len == 8'd1 && !grow_now) begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
          end else begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (bus.grow) grow_pend <= 1'b1;
          if (hit) begin
            state         <= ST_DEAD;
            bus.busy      <= 1'b0;
            bus.game_over <= 1'b1;
          end else if (chk_k == len - 8'd1) begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
          end else begin
            chk_k <= chk_k + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
